// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for an N-input, W-bit select datapath. Registers the granted
// word onto a valid/ready channel and pulses a one-hot acknowledge back to the producer.
module rr_mux_arbiter #(
    parameter int N = 4,
    parameter int m = 2,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [m-1:0]   sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   ack,
    output logic           busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [m-1:0]   ptr_q, ptr_d;
    logic [m-1:0]   sel_q, sel_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   ack_q, ack_d;

    logic [N-1:0]   ereq;
    logic [m-1:0]   cand;
    logic [m-1:0]   win;
    logic           found;

    // Scan ptr+1, ptr+2, ... wrapping at N (not 2**m), so unused indices never win.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a missed path would infer a latch.
        ereq  = req & ~ack_q;
        cand  = ptr_q;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (cand == m'(N - 1)) ? '0 : cand + 1'b1;
            if (!found && ereq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d       = win;
                    out_data_d  = data_in[win*W +: W];
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Requests are ignored here; the captured word is always delivered.
                if (out_valid_q && out_ready) begin
                    out_valid_d  = 1'b0;
                    ack_d[sel_q] = 1'b1;
                    ptr_d        = sel_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= m'(N - 1);
            sel_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ack       = ack_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: a 4-input and a 3-input instance run against a
// transaction-level reference model, plus directed scenarios with hand-derived expectations.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_a;
    logic [15:0] din_a;
    logic        rdy_a;
    logic [1:0]  sel_a;
    logic [3:0]  od_a;
    logic        ov_a;
    logic [3:0]  ack_a;
    logic        busy_a;

    logic [2:0]  req_b;
    logic [11:0] din_b;
    logic        rdy_b;
    logic [1:0]  sel_b;
    logic [3:0]  od_b;
    logic        ov_b;
    logic [2:0]  ack_b;
    logic        busy_b;

    int checks   = 0;
    int failures = 0;

    rr_mux_arbiter #(.N(4), .m(2), .W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(din_a),
        .sel(sel_a), .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a),
        .ack(ack_a), .busy(busy_a)
    );

    rr_mux_arbiter #(.N(3), .m(2), .W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(din_b),
        .sel(sel_b), .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b),
        .ack(ack_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one pending transaction plus the index of the last served requester.
    typedef struct {
        bit pending;
        int last;
        int sel;
        int word;
        int ack;
    } model_t;

    model_t ms[2];

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(int d, int n, bit rst, int rq, logic [15:0] din, bit rdy);
        int eligible;
        int w;
        if (!rst) begin
            ms[d].pending = 0;
            ms[d].last    = n - 1;
            ms[d].sel     = 0;
            ms[d].word    = 0;
            ms[d].ack     = 0;
        end else if (!ms[d].pending) begin
            eligible  = rq & ~ms[d].ack;
            ms[d].ack = 0;
            w = -1;
            for (int k = 1; k <= n; k++) begin
                int i;
                i = (ms[d].last + k) % n;
                if (w < 0 && ((eligible >> i) & 1) == 1) w = i;
            end
            if (w >= 0) begin
                ms[d].pending = 1;
                ms[d].sel     = w;
                ms[d].word    = int'((din >> (w * 4)) & 16'hf);
            end
        end else begin
            ms[d].ack = 0;
            if (rdy) begin
                ms[d].pending = 0;
                ms[d].ack     = 1 << ms[d].sel;
                ms[d].last    = ms[d].sel;
            end
        end
    endtask

    task automatic compare_all();
        check("a_sel",   32'(sel_a),  32'(ms[0].sel));
        check("a_data",  32'(od_a),   32'(ms[0].word));
        check("a_valid", 32'(ov_a),   32'(ms[0].pending));
        check("a_ack",   32'(ack_a),  32'(ms[0].ack));
        check("a_busy",  32'(busy_a), 32'(ms[0].pending));
        check("b_sel",   32'(sel_b),  32'(ms[1].sel));
        check("b_data",  32'(od_b),   32'(ms[1].word));
        check("b_valid", 32'(ov_b),   32'(ms[1].pending));
        check("b_ack",   32'(ack_b),  32'(ms[1].ack));
        check("b_busy",  32'(busy_b), 32'(ms[1].pending));
        check("b_sel_range", 32'(sel_b < 2'd3), 32'd1);
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later, inputs change at negedge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, 4, rst_n, int'(req_a), din_a, rdy_a);
        model_step(1, 3, rst_n, int'(req_b), {4'h0, din_b}, rdy_b);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 4'b1111; din_a = 16'h4321; rdy_a = 1'b1;
        req_b = 3'b000;  din_b = 12'h000;  rdy_b = 1'b1;

        // Reset held two cycles with all requests high.
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst_sel",   32'(sel_a),  0);
            check("rst_data",  32'(od_a),   0);
            check("rst_valid", 32'(ov_a),   0);
            check("rst_ack",   32'(ack_a),  0);
            check("rst_busy",  32'(busy_a), 0);
        end

        // Release: first grant is requester 0, then strict rotation one word per 2 cycles.
        rst_n = 1'b1;
        cycle();
        check("rot_first_sel",   32'(sel_a), 0);
        check("rot_first_data",  32'(od_a),  1);
        check("rot_first_valid", 32'(ov_a),  1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("rot_ack",   32'(ack_a), 32'(1 << ((k - 1) % 4)));
            check("rot_idle",  32'(ov_a),  0);
            cycle();
            check("rot_sel",   32'(sel_a), 32'(k % 4));
            check("rot_data",  32'(od_a),  32'(k % 4 + 1));
        end

        // Single requester with held request: masked during its ack cycle.
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req_a = 4'b0010; din_a = 16'h0080; rdy_a = 1'b1;
        cycle();
        check("single_valid", 32'(ov_a),  1);
        check("single_sel",   32'(sel_a), 1);
        check("single_data",  32'(od_a),  4'b1000);
        cycle();
        check("single_ack",   32'(ack_a), 4'b0010);
        check("single_drop",  32'(ov_a),  0);
        cycle();
        check("single_masked", 32'(ov_a),  0);
        check("single_noack",  32'(ack_a), 0);
        cycle();
        check("single_regrant", 32'(ov_a),  1);
        check("single_resel",   32'(sel_a), 1);

        // Backpressure: word held stable while req/data_in churn.
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req_a = 4'b0100; din_a = 16'h0500; rdy_a = 1'b0;
        cycle();
        check("bp_sel", 32'(sel_a), 2);
        for (int i = 0; i < 5; i++) begin
            req_a = 4'($urandom);
            din_a = 16'($urandom);
            cycle();
            check("bp_hold_data", 32'(od_a),   4'b0101);
            check("bp_hold_sel",  32'(sel_a),  2);
            check("bp_no_ack",    32'(ack_a),  0);
            check("bp_busy",      32'(busy_a), 1);
        end
        rdy_a = 1'b1; req_a = 4'b0000;
        cycle();
        check("bp_ack",   32'(ack_a), 4'b0100);
        check("bp_valid", 32'(ov_a),  0);

        // Reset in SEND drops the word with no ack and restores priority to requester 0.
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req_a = 4'b1000; din_a = 16'h9000; rdy_a = 1'b0;
        cycle();
        check("mid_busy", 32'(busy_a), 1);
        rst_n = 1'b0;
        cycle();
        check("mid_valid", 32'(ov_a),   0);
        check("mid_ack",   32'(ack_a),  0);
        check("mid_busy0", 32'(busy_a), 0);
        rst_n = 1'b1; req_a = 4'b1111;
        cycle();
        check("mid_regrant", 32'(sel_a), 0);
        req_a = 4'b0000; rdy_a = 1'b1;
        cycle();

        // Three-input instance: wrap from 2 to 0, skipping unused index 3.
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req_b = 3'b100; din_b = 12'h700; rdy_b = 1'b1;
        cycle();
        check("wrap_sel2", 32'(sel_b), 2);
        check("wrap_data2", 32'(od_b), 7);
        req_b = 3'b101; din_b = 12'h705;
        cycle();
        check("wrap_ack2", 32'(ack_b), 3'b100);
        cycle();
        check("wrap_sel0", 32'(sel_b), 0);
        check("wrap_data0", 32'(od_b), 5);
        cycle();
        check("wrap_ack0", 32'(ack_b), 3'b001);
        cycle();
        check("wrap_sel2b", 32'(sel_b), 2);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req_a = 4'($urandom);
            din_a = 16'($urandom);
            rdy_a = ($urandom_range(0, 3) != 0);
            req_b = 3'($urandom);
            din_b = 12'($urandom);
            rdy_b = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared W-bit N-input select datapath (the w_bit_N_MUX channel). It takes per-requester request lines and W-bit data words, grants one requester at a time in fair rotating order, and drives the mux select. It registers the selected word onto a single valid/ready output channel and returns a one-cycle acknowledge to the served requester. It sits between N producer blocks and one downstream W-bit consumer.

## Interface
- N, 4, number of requesters / mux inputs; 2 ≤ N ≤ 2**m
- m, 2, select width; must satisfy 2**m ≥ N
- W, 4, data word width
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- req  input  N  per-requester request level; req[i] high means data_in word i is valid
- data_in  input  N*W  flattened words; requester i occupies bits [i*W +: W]
- sel  output  m  registered select index of current/last grant; drives the mux sel
- out_data  output  W  registered word of the granted requester
- out_valid  output  1  out_data holds a word awaiting consumption
- out_ready  input  1  downstream accepts out_data this cycle when out_valid high
- ack  output  N  one-hot, one-cycle pulse: word of requester i consumed
- busy  output  1  high while in SEND state

## Operation
- Two-state FSM: IDLE, SEND.
- Internal pointer ptr (m bits) holds index of last served requester; reset value N-1 so requester 0 has first priority.
- Effective request: ereq = req & ~ack. The requester just acknowledged is masked for the acknowledge cycle, so a held req is never served twice from one word.
- IDLE: if ereq == 0, stay. Otherwise winner w = first set bit of ereq scanning indices ptr+1, ptr+2, …, wrapping modulo N (not modulo 2**m). Next edge: sel<=w, out_data<=data_in[w*W +: W], out_valid<=1, state<=SEND.
- SEND: sel, out_data, out_valid held stable. On out_valid && out_ready: out_valid<=0, ack<=(1<<w), ptr<=w, state<=IDLE.
- ack is high for exactly one cycle (the first IDLE cycle after a handshake); otherwise 0.
- Requests are not sampled in SEND. A requester dropping req during SEND does not cancel the transfer; the captured word is delivered and acked.
- data_in changes after capture do not affect out_data.
- Indices ≥ N never win; sel never exceeds N-1.
- busy = (state == SEND).

## Timing
- Reset (rst_n low at an edge): state=IDLE, ptr=N-1, sel=0, out_data=0, out_valid=0, ack=0, busy=0. Reset mid-SEND drops the pending word with no ack.
- Latency: req rising in cycle t (state IDLE) -> out_valid high from cycle t+1.
- Handshake at edge e -> ack pulse and out_valid low in cycle e+1; next grant may be captured at edge e+1 -> out_valid high at e+2.
- Peak throughput: one word per 2 cycles with out_ready tied high.
- out_ready low indefinitely: hold SEND, all outputs stable, no timeout.
- out_ready is ignored while out_valid is low.
- Fairness: with all N requests continuously high, grants go 0,1,…,N-1,0,… ; any asserted request is served within N grants.

## Test plan
- Reset: rst_n low 2 cycles with req=4'b1111 -> sel=0, out_data=0, out_valid=0, ack=0, busy=0; after release, first grant is requester 0.
- Single requester: req=4'b0010, word1=4'b1000, out_ready=1 -> out_valid high one cycle after req, sel=1, out_data=4'b1000, then ack=4'b0010 for one cycle; while req held, next grant to 1 again two cycles later.
- Rotation: req=4'b1111, words 4'h1,4'h2,4'h3,4'h4 for requesters 0..3, out_ready=1 -> out_data sequence 1,2,3,4,1,… one word per 2 cycles; sel 0,1,2,3,0.
- Backpressure: grant requester 2 (word 4'b0101), out_ready=0 for 5 cycles while changing data_in and req -> out_data stays 4'b0101, sel=2, no ack; out_ready=1 -> ack=4'b0100 next cycle.
- Wrap and skip: N=3, m=2, ptr=2 after serving 2, req=3'b101 -> next grant 0, then 2; sel never 3.
- Mid-transfer reset: reset asserted in SEND -> out_valid 0 next cycle, no ack, ptr back to N-1.
